// File: rtl/timer0_pkg.sv
// Shared constants and types for the Timer0 counter block.
package timer0_pkg;

    localparam int WIDTH = 8;
    localparam logic [WIDTH-1:0] MAX = 8'hFF;

    typedef enum logic {
        MODE_NORMAL = 1'b0,
        MODE_CTC    = 1'b1
    } mode_e;

    // Bit positions inside flag_clr
    localparam int TOV_BIT = 0;
    localparam int OCF_BIT = 1;

endpackage

// File: rtl/timer0_counter_tick_sync.sv
// Two-flop synchroniser plus registered rising-edge detector.
// The pulse is suppressed until the synchroniser chain holds real samples
// taken after reset, so a level already high at reset release is not an edge.
module tick_sync (
    input  logic clk,
    input  logic rst,
    input  logic async_in,
    output logic pulse_out
);

    logic       s1_r;
    logic       s2_r;
    logic       s3_r;
    logic [2:0] vld_r;
    logic       pulse_r;

    // Synchroniser chain, sample-validity shift and registered edge pulse
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_r    <= 1'b0;
            s2_r    <= 1'b0;
            s3_r    <= 1'b0;
            vld_r   <= 3'b000;
            pulse_r <= 1'b0;
        end else begin
            s1_r    <= async_in;
            s2_r    <= s1_r;
            s3_r    <= s2_r;
            vld_r   <= {vld_r[1:0], 1'b1};
            pulse_r <= s2_r & ~s3_r & vld_r[2];
        end
    end

    assign pulse_out = pulse_r;

endmodule

// File: rtl/timer0_counter.sv
// Timer0 count register with compare, normal/CTC modes, sticky flags and irq.
module timer0_counter
    import timer0_pkg::*;
#(
    parameter int WIDTH = timer0_pkg::WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tick_in,
    input  logic             en,
    input  logic             ctc_mode,
    input  logic             tcnt_wr,
    input  logic             ocr_wr,
    input  logic [WIDTH-1:0] din,
    input  logic [1:0]       flag_clr,
    input  logic             toie,
    input  logic             ocie,
    output logic [WIDTH-1:0] tcnt,
    output logic [WIDTH-1:0] ocr,
    output logic             tov,
    output logic             ocf,
    output logic             irq
);

    localparam logic [WIDTH-1:0] MAX_V  = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] ZERO_V = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] ONE_V  = {{(WIDTH-1){1'b0}}, 1'b1};

    logic             tick_p_s;
    logic             eff_tick_s;
    logic             match_s;
    logic             at_max_s;
    logic [WIDTH-1:0] tcnt_nxt_s;
    logic             tov_set_s;
    logic             ocf_set_s;
    logic             tov_nxt_s;
    logic             ocf_nxt_s;

    logic [WIDTH-1:0] tcnt_r;
    logic [WIDTH-1:0] ocr_r;
    logic             tov_r;
    logic             ocf_r;
    logic             irq_r;

    tick_sync u_tick_sync (
        .clk      (clk),
        .rst      (rst),
        .async_in (tick_in),
        .pulse_out(tick_p_s)
    );

    // A software write to tcnt swallows any tick landing in the same cycle
    assign eff_tick_s = tick_p_s & en & ~tcnt_wr;
    assign match_s    = (tcnt_r == ocr_r);
    assign at_max_s   = (tcnt_r == MAX_V);

    // Next count and flag-set conditions
    always_comb begin
        tcnt_nxt_s = tcnt_r;
        tov_set_s  = 1'b0;
        ocf_set_s  = 1'b0;
        if (tcnt_wr) begin
            tcnt_nxt_s = din;
        end else if (eff_tick_s) begin
            ocf_set_s = match_s;
            tov_set_s = at_max_s;
            if (((ctc_mode == MODE_CTC) && match_s) || at_max_s) begin
                tcnt_nxt_s = ZERO_V;
            end else begin
                tcnt_nxt_s = tcnt_r + ONE_V;
            end
        end else begin
            tcnt_nxt_s = tcnt_r;
        end
        // Setting wins over a simultaneous write-1-to-clear
        tov_nxt_s = tov_set_s | (tov_r & ~flag_clr[TOV_BIT]);
        ocf_nxt_s = ocf_set_s | (ocf_r & ~flag_clr[OCF_BIT]);
    end

    // Counter, compare, flag and interrupt registers
    always_ff @(posedge clk) begin
        if (rst) begin
            tcnt_r <= ZERO_V;
            ocr_r  <= MAX_V;
            tov_r  <= 1'b0;
            ocf_r  <= 1'b0;
            irq_r  <= 1'b0;
        end else begin
            tcnt_r <= tcnt_nxt_s;
            if (ocr_wr) begin
                ocr_r <= din;
            end
            tov_r  <= tov_nxt_s;
            ocf_r  <= ocf_nxt_s;
            irq_r  <= (tov_nxt_s & toie) | (ocf_nxt_s & ocie);
        end
    end

    assign tcnt = tcnt_r;
    assign ocr  = ocr_r;
    assign tov  = tov_r;
    assign ocf  = ocf_r;
    assign irq  = irq_r;

endmodule
